// File: rtl/imul_mul_share_arb_pkg.sv
// imul_arb_pkg: state encodings and message widths shared by the multiplier arbiter
package imul_arb_pkg;
  typedef enum logic {STATE_IDLE = 1'b0, STATE_WAIT = 1'b1} state_t;
  localparam int REQ_MSG_W = 64;
  localparam int RESP_MSG_W = 32;
endpackage

// File: rtl/imul_mul_share_arb_if.sv
// imul_mul_share_arb_if: requester-side and multiplier-side val/rdy bundle of the arbiter
interface imul_mul_share_arb_if
  import imul_arb_pkg::*;
#(parameter int NREQ = 2);
  logic [NREQ-1:0] req_val, req_rdy, resp_val, resp_rdy;
  logic [NREQ*REQ_MSG_W-1:0] req_msg;
  logic [RESP_MSG_W-1:0] resp_msg, mul_resp_msg;
  logic [REQ_MSG_W-1:0] mul_req_msg;
  logic mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  modport master (
    input req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    output req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
  );
  modport slave (
    output req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    input req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
  );
endinterface

// File: rtl/imul_mul_share_arb_rr_grant.sv
// imul_rr_grant: rotate-priority encoder picking the first requester at or after prio
module imul_rr_grant #(
  parameter int NREQ = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] prio,
  output logic [IDX_W-1:0] grant,
  output logic             any
);
  int j;
  // scan from the far end so the lane closest to prio is written last and wins
  always_comb begin
    grant = '0;
    j = 0;
    any = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(prio) + k) % NREQ;
      if (req[j]) grant = IDX_W'(j);
    end
  end
endmodule

// File: rtl/imul_mul_share_arb.sv
// imul_mul_share_arb: round-robin sharing of one val/rdy multiplier among NREQ requesters
module imul_mul_share_arb
  import imul_arb_pkg::*;
#(parameter int NREQ = 2) (
  input logic clk,
  input logic reset,
  imul_mul_share_arb_if.master bus,
  output logic busy
);
  localparam int IDX_W = $clog2(NREQ);
  state_t state, state_nx;
  logic [IDX_W-1:0] owner, prio, grant;
  logic any, idle, req_fire, resp_fire;
  imul_rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
    .req(bus.req_val), .prio(prio), .grant(grant), .any(any)
  );
  always_comb begin
    idle = state == STATE_IDLE;
    req_fire = idle && any && bus.mul_req_rdy;
    resp_fire = !idle && bus.mul_resp_val && bus.resp_rdy[owner];
    state_nx = req_fire ? STATE_WAIT : resp_fire ? STATE_IDLE : state;
    busy = !idle;
    bus.mul_req_val = idle && any;
    bus.mul_req_msg = idle && any ? bus.req_msg[grant*REQ_MSG_W +: REQ_MSG_W] : '0;
    bus.req_rdy = idle && any && bus.mul_req_rdy ? NREQ'(1) << grant : '0;
    bus.resp_val = !idle && bus.mul_resp_val ? NREQ'(1) << owner : '0;
    bus.mul_resp_rdy = !idle && bus.resp_rdy[owner];
    bus.resp_msg = !idle && bus.mul_resp_val ? bus.mul_resp_msg : '0;
  end
  // prio advances only on completion so a grant can move freely while the multiplier stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_IDLE;
      owner <= '0;
      prio <= '0;
    end else begin
      state <= state_nx;
      if (req_fire) owner <= grant;
      if (resp_fire) prio <= owner == IDX_W'(NREQ - 1) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_imul_mul_share_arb.sv
// tb_imul_mul_share_arb: directed checks of the arbiter with NREQ=2 and NREQ=3 against behavioural multipliers
module tb_imul_mul_share_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy2, busy3;
  int total = 0, bad = 0, lat2 = 2, lat3 = 1;
  always #5 clk = ~clk;
  imul_mul_share_arb_if #(.NREQ(2)) b2 ();
  imul_mul_share_arb_if #(.NREQ(3)) b3 ();
  imul_mul_share_arb #(.NREQ(2)) u2 (.clk(clk), .reset(reset), .bus(b2), .busy(busy2));
  imul_mul_share_arb #(.NREQ(3)) u3 (.clk(clk), .reset(reset), .bus(b3), .busy(busy3));
  logic [63:0] q2 [2][$];
  logic [63:0] q3 [3][$];
  logic [35:0] log2 [$];
  logic [35:0] log3 [$];
  logic [1:0] s_rv2, s_rr2, acc_rv2;
  logic s_busy2, s_mrv2, s_mrr2, acc_busy2;
  logic [31:0] s_msg2;
  logic [63:0] s_mrm2;
  logic [63:0] t3_l0 [4] = '{{32'd1, 32'd2}, {32'hFFFFFFFF, 32'd2}, {32'd10, 32'd10}, {32'h10000, 32'h10000}};
  logic [63:0] t3_l1 [4] = '{{32'd3, 32'd3}, {32'd5, 32'd7}, {32'hFFFF, 32'hFFFF}, {32'd100, 32'd0}};
  logic [35:0] t3_exp [8] = '{36'h0_00000002, 36'h1_00000009, 36'h0_FFFFFFFE, 36'h1_00000023,
                              36'h0_00000064, 36'h1_FFFE0001, 36'h0_00000000, 36'h1_00000000};
  // multiplier models: product is held after completion so the arbiter's output gating is visible
  logic m2_busy, m3_busy;
  logic [3:0] m2_cnt, m3_cnt;
  logic [31:0] m2_prod, m3_prod;
  assign b2.mul_req_rdy = !m2_busy;
  assign b2.mul_resp_val = m2_busy && m2_cnt == 4'd0;
  assign b2.mul_resp_msg = m2_prod;
  assign b3.mul_req_rdy = !m3_busy;
  assign b3.mul_resp_val = m3_busy && m3_cnt == 4'd0;
  assign b3.mul_resp_msg = m3_prod;
  always @(posedge clk) begin
    if (reset) begin
      m2_busy <= 1'b0;
      m2_cnt <= '0;
      m2_prod <= '0;
    end else if (!m2_busy) begin
      if (b2.mul_req_val) begin
        m2_busy <= 1'b1;
        m2_cnt <= 4'(lat2);
        m2_prod <= b2.mul_req_msg[63:32] * b2.mul_req_msg[31:0];
      end
    end else if (m2_cnt != 4'd0) m2_cnt <= m2_cnt - 4'd1;
    else if (b2.mul_resp_rdy) m2_busy <= 1'b0;
  end
  always @(posedge clk) begin
    if (reset) begin
      m3_busy <= 1'b0;
      m3_cnt <= '0;
      m3_prod <= '0;
    end else if (!m3_busy) begin
      if (b3.mul_req_val) begin
        m3_busy <= 1'b1;
        m3_cnt <= 4'(lat3);
        m3_prod <= b3.mul_req_msg[63:32] * b3.mul_req_msg[31:0];
      end
    end else if (m3_cnt != 4'd0) m3_cnt <= m3_cnt - 4'd1;
    else if (b3.mul_resp_rdy) m3_busy <= 1'b0;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] pick(input logic [35:0] q [$], input int k);
    return k < q.size() ? q[k] : '1;
  endfunction
  task automatic tick();
    logic [1:0] f2;
    logic [2:0] f3;
    @(negedge clk);
    f2 = reset ? '0 : b2.req_val & b2.req_rdy;
    f3 = reset ? '0 : b3.req_val & b3.req_rdy;
    s_rv2 = b2.resp_val;
    s_rr2 = b2.req_rdy;
    s_busy2 = busy2;
    s_msg2 = b2.resp_msg;
    s_mrv2 = b2.mul_req_val;
    s_mrr2 = b2.mul_resp_rdy;
    s_mrm2 = b2.mul_req_msg;
    acc_rv2 |= b2.resp_val;
    acc_busy2 |= busy2;
    for (int i = 0; i < 2; i++)
      if (!reset && b2.resp_val[i] && b2.resp_rdy[i]) log2.push_back({4'(i), b2.resp_msg});
    for (int i = 0; i < 3; i++)
      if (!reset && b3.resp_val[i] && b3.resp_rdy[i]) log3.push_back({4'(i), b3.resp_msg});
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (f2[i]) void'(q2[i].pop_front());
      b2.req_val[i] = q2[i].size() != 0;
      b2.req_msg[64*i +: 64] = q2[i].size() != 0 ? q2[i][0] : '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (f3[i]) void'(q3[i].pop_front());
      b3.req_val[i] = q3[i].size() != 0;
      b3.req_msg[64*i +: 64] = q3[i].size() != 0 ? q3[i][0] : '0;
    end
  endtask
  task automatic run_until(input int n2, input int n3, input string tag);
    int c = 0;
    while ((log2.size() < n2 || log3.size() < n3) && c < 300) begin
      tick();
      c++;
    end
    check(tag, 64'(c < 300), 64'd1);
  endtask
  initial begin
    b2.req_val = '0;
    b2.req_msg = '0;
    b2.resp_rdy = '1;
    b3.req_val = '0;
    b3.req_msg = '0;
    b3.resp_rdy = '1;
    acc_rv2 = '0;
    acc_busy2 = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_req_rdy", 64'(s_rr2), 64'd0);
    check("rst_resp_val", 64'(s_rv2), 64'd0);
    check("rst_mul_req_val", 64'(s_mrv2), 64'd0);
    check("rst_mul_resp_rdy", 64'(s_mrr2), 64'd0);
    check("rst_busy", 64'(s_busy2), 64'd0);
    check("rst_mul_req_msg", s_mrm2, 64'd0);
    check("rst_resp_msg", 64'(s_msg2), 64'd0);
    check("rst_prio", 64'(u2.prio), 64'd0);
    // single request on lane0
    log2.delete();
    acc_rv2 = '0;
    acc_busy2 = 1'b0;
    q2[0].push_back({32'd3, 32'd5});
    run_until(1, 0, "t1_timeout");
    check("t1_resp", 64'(pick(log2, 0)), 64'h0_0000000F);
    check("t1_lane1_quiet", 64'(acc_rv2[1]), 64'd0);
    check("t1_busy_seen", 64'(acc_busy2), 64'd1);
    tick();
    check("t1_idle_resp_msg", 64'(s_msg2), 64'd0);
    check("t1_idle_busy", 64'(s_busy2), 64'd0);
    // contention from reset
    reset = 1'b1;
    q2[0].push_back({32'd7, 32'd6});
    q2[1].push_back({32'd4, 32'd9});
    repeat (2) tick();
    reset = 1'b0;
    log2.delete();
    run_until(2, 0, "t2_timeout");
    check("t2_first", 64'(pick(log2, 0)), 64'h0_0000002A);
    check("t2_second", 64'(pick(log2, 1)), 64'h1_00000024);
    check("t2_prio", 64'(u2.prio), 64'd0);
    // continuous streaming on both lanes alternates grants
    lat2 = 3;
    log2.delete();
    for (int k = 0; k < 4; k++) begin
      q2[0].push_back(t3_l0[k]);
      q2[1].push_back(t3_l1[k]);
    end
    run_until(8, 0, "t3_timeout");
    for (int k = 0; k < 8; k++) check($sformatf("t3_resp%0d", k), 64'(pick(log2, k)), 64'(t3_exp[k]));
    // response backpressure on lane1 with lane0 waiting behind it
    lat2 = 2;
    log2.delete();
    b2.resp_rdy[1] = 1'b0;
    q2[1].push_back({32'h80000000, 32'd2});
    tick();
    for (int c = 0; c < 50 && !s_rv2[1]; c++) tick();
    check("t4_resp_seen", 64'(s_rv2[1]), 64'd1);
    q2[0].push_back({32'd2, 32'd2});
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t4_hold_val%0d", k), 64'(s_rv2), 64'd2);
      check($sformatf("t4_hold_rdy%0d", k), 64'(s_rr2), 64'd0);
      check($sformatf("t4_hold_msg%0d", k), 64'(s_msg2), 64'd0);
    end
    check("t4_no_early_fire", 64'(log2.size()), 64'd0);
    b2.resp_rdy[1] = 1'b1;
    run_until(2, 0, "t4_timeout");
    check("t4_first", 64'(pick(log2, 0)), 64'h1_00000000);
    check("t4_second", 64'(pick(log2, 1)), 64'h0_00000004);
    check("t4_prio", 64'(u2.prio), 64'd1);
    // reset while lane1 is in flight
    lat2 = 5;
    log2.delete();
    q2[1].push_back({32'd6, 32'd7});
    tick();
    for (int c = 0; c < 20 && !s_busy2; c++) tick();
    check("t5_busy", 64'(s_busy2), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t5_busy_clr", 64'(s_busy2), 64'd0);
    check("t5_resp_val", 64'(s_rv2), 64'd0);
    check("t5_req_rdy", 64'(s_rr2), 64'd0);
    check("t5_mul_req_val", 64'(s_mrv2), 64'd0);
    check("t5_mul_resp_rdy", 64'(s_mrr2), 64'd0);
    check("t5_prio", 64'(u2.prio), 64'd0);
    repeat (8) tick();
    check("t5_dropped", 64'(log2.size()), 64'd0);
    lat2 = 1;
    q2[1].push_back({32'd2, 32'd3});
    run_until(1, 0, "t5_timeout");
    check("t5_after", 64'(pick(log2, 0)), 64'h1_00000006);
    // NREQ=3 wrap-around starting from prio=2
    log3.delete();
    q3[1].push_back({32'd1, 32'd1});
    run_until(0, 1, "t6a_timeout");
    check("t6_prio_start", 64'(u3.prio), 64'd2);
    log3.delete();
    q3[0].push_back({32'd9, 32'd0});
    q3[1].push_back({32'd6, 32'd7});
    q3[2].push_back({32'd11, 32'd3});
    run_until(0, 3, "t6_timeout");
    check("t6_first", 64'(pick(log3, 0)), 64'h2_00000021);
    check("t6_second", 64'(pick(log3, 1)), 64'h0_00000000);
    check("t6_third", 64'(pick(log3, 2)), 64'h1_0000002A);
    check("t6_prio_end", 64'(u3.prio), 64'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
